// File: rtl/panda_pkg.sv
// Shared types for the panda core's data-bus adapter: FSM state encoding and
// the byte-enable rule applied to bus requests.
package panda_pkg;

    typedef enum logic [1:0] {
        DATA_BUS_IDLE,
        DATA_BUS_REQ,
        DATA_BUS_WAIT,
        DATA_BUS_DONE
    } data_bus_state_e;

    // Loads always fetch the full word; stores use the core's byte enables.
    function automatic logic [3:0] bus_be(input logic [3:0] we);
        return (we == 4'h0) ? 4'hF : we;
    endfunction

endpackage

// File: rtl/panda_data_bus_adapter.sv
// Bridges the core's single-cycle load/store interface to a req/gnt/rvalid bus,
// stalling the core until the response arrives. Optional abort timer: PANDA_DATA_TIMEOUT_EN.
module panda_data_bus_adapter
    import panda_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        core_req_i,
    input  logic [3:0]  core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic [31:0] core_rdata_o,
    output logic        core_err_o,
    output logic        core_stall_o,
    output logic        data_req_o,
    input  logic        data_gnt_i,
    output logic [31:0] data_addr_o,
    output logic        data_we_o,
    output logic [3:0]  data_be_o,
    output logic [31:0] data_wdata_o,
    input  logic        data_rvalid_i,
    input  logic [31:0] data_rdata_i,
    input  logic        data_err_i
);

    data_bus_state_e state, state_next;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            capture;
    logic            timeout;

    // Payload comes straight from the core, which holds it stable while stalled.
    assign data_addr_o  = {core_addr_i[31:2], 2'b00};
    assign data_we_o    = |core_we_i;
    assign data_be_o    = bus_be(core_we_i);
    assign data_wdata_o = core_wdata_i;

    logic unused_addr_bits;
    assign unused_addr_bits = ^core_addr_i[1:0];

`ifdef PANDA_DATA_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;

    assign timeout = (cnt_q == CntW'(TimeoutCycles - 1));

    // Restarts on every entry to REQ or WAIT, so each phase gets its own budget.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (state_next != state &&
                     (state_next == DATA_BUS_REQ || state_next == DATA_BUS_WAIT)) begin
            cnt_q <= '0;
        end else if (state == DATA_BUS_REQ || state == DATA_BUS_WAIT) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
`else
    logic [31:0] unused_timeout_cycles;
    assign unused_timeout_cycles = 32'(TimeoutCycles);
    assign timeout = 1'b0;
`endif

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_next   = state;
        capture      = 1'b0;
        rdata_d      = data_rdata_i;
        err_d        = data_err_i;
        data_req_o   = 1'b0;
        core_stall_o = 1'b0;
        unique case (state)
            DATA_BUS_IDLE: begin
                data_req_o   = core_req_i;
                core_stall_o = core_req_i;
                if (core_req_i) begin
                    state_next = data_gnt_i ? DATA_BUS_WAIT : DATA_BUS_REQ;
                end
            end
            DATA_BUS_REQ: begin
                data_req_o   = 1'b1;
                core_stall_o = 1'b1;
                if (data_gnt_i) begin
                    state_next = DATA_BUS_WAIT;
                end else if (timeout) begin
                    state_next = DATA_BUS_DONE;
                    capture    = 1'b1;
                    rdata_d    = '0;
                    err_d      = 1'b1;
                end
            end
            DATA_BUS_WAIT: begin
                core_stall_o = 1'b1;
                if (data_rvalid_i) begin
                    state_next = DATA_BUS_DONE;
                    capture    = 1'b1;
                end else if (timeout) begin
                    state_next = DATA_BUS_DONE;
                    capture    = 1'b1;
                    rdata_d    = '0;
                    err_d      = 1'b1;
                end
            end
            DATA_BUS_DONE: state_next = DATA_BUS_IDLE;
            default:       state_next = DATA_BUS_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= DATA_BUS_IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_next;
            if (capture) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    // Error is a one-cycle retire-time signal; read data simply holds its last capture.
    assign core_rdata_o = rdata_q;
    assign core_err_o   = err_q && (state == DATA_BUS_DONE);

endmodule

// File: doc/panda_data_bus_adapter.md
PANDA_DATA_BUS_ADAPTER -- requirements
Module: panda_data_bus_adapter

Interface
REQ-001 SHALL have parameter TimeoutCycles, default 255, meaning max cycles waiting on gnt or rvalid before abort (used only with PANDA_DATA_TIMEOUT_EN).
REQ-002 SHALL have one clock and an asynchronous, active-high reset: clk_i input 1 (rising-edge clock); rst_i input 1 (asynchronous reset, active-high).
REQ-003 core_req_i input 1: core requests a load or store this instruction.
REQ-004 core_we_i input 4: byte write enables; 4'h0 means load.
REQ-005 core_addr_i input 32 and core_wdata_i input 32: access address and store data, held stable by the core while core_stall_o=1.
REQ-006 core_rdata_o output 32 and core_err_o output 1: load data and bus error, valid only while core_stall_o=0 in DONE.
REQ-007 core_stall_o output 1: freezes PC and register-file write.
REQ-008 data_req_o output 1 and data_gnt_i input 1: bus request/grant.
REQ-009 data_addr_o output 32, data_we_o output 1, data_be_o output 4, data_wdata_o output 32: bus request payload.
REQ-010 data_rvalid_i input 1, data_rdata_i input 32, data_err_i input 1: bus response.

Function
REQ-011 SHALL implement FSM IDLE, REQ, WAIT, DONE.
REQ-012 IDLE: data_req_o=core_req_i; on req&gnt -> WAIT; on req&!gnt -> REQ; else stay.
REQ-013 REQ: data_req_o=1 with payload unchanged; on gnt -> WAIT.
REQ-014 WAIT: data_req_o=0; on rvalid, capture data_rdata_i and data_err_i into registers -> DONE.
REQ-015 DONE: core_stall_o=0, core_rdata_o=captured data, core_err_o=captured err; unconditionally -> IDLE.
REQ-016 core_stall_o=1 in IDLE when core_req_i=1, and in REQ and WAIT; 0 otherwise.
REQ-017 Payload: data_addr_o={core_addr_i[31:2],2'b00}; data_we_o=|core_we_i; data_be_o=core_we_i if store, 4'hF if load; data_wdata_o=core_wdata_i.
REQ-018 Minimum latency with gnt and rvalid on consecutive cycles: stall high 2 cycles, instruction retires in 3rd cycle.
REQ-019 data_rvalid_i outside WAIT SHALL be ignored; data_gnt_i outside IDLE/REQ SHALL be ignored.
REQ-020 At most one outstanding transaction; no new request is issued in WAIT or DONE.
REQ-021 Stores SHALL also pass through WAIT/DONE; core_rdata_o carries the captured rdata but is ignored by the core.

Reset
REQ-022 On rst_i assertion, immediately: state=IDLE, captured data=0, captured err=0, timeout counter=0; core_rdata_o=0, core_err_o=0.
REQ-023 Reset mid-transaction SHALL drop data_req_o at once; a late rvalid after reset release is ignored per REQ-019.

Configuration
REQ-024 With PANDA_DATA_TIMEOUT_EN defined: counter clears on entry to REQ/WAIT and increments each cycle there; reaching TimeoutCycles forces DONE with core_err_o=1 and core_rdata_o=0.
REQ-025 Without PANDA_DATA_TIMEOUT_EN: no counter, and the adapter waits indefinitely in REQ/WAIT.

Structure
REQ-026 The state enum data_bus_state_e {DATA_BUS_IDLE, DATA_BUS_REQ, DATA_BUS_WAIT, DATA_BUS_DONE} SHALL reside in panda_pkg.
REQ-027 No sub-module; the counter is inline, and the block instantiates between the datapath's data_* ports and the bus.

Verification
REQ-028 Load addr 0x1003, gnt same cycle, rvalid next with rdata 0xDEADBEEF -> data_addr_o=0x1000, be=4'hF, stall 2 cycles, core_rdata_o=0xDEADBEEF in DONE.
REQ-029 Store we=4'b0011, gnt delayed 3 cycles -> data_req_o held 4 cycles with stable payload, data_we_o=1, data_be_o=4'b0011, stall 5 cycles.
REQ-030 Load with data_err_i=1 on rvalid -> core_err_o=1 for exactly one cycle in DONE.
REQ-031 rst_i pulsed in WAIT, then rvalid -> state IDLE, data_req_o=0, stall=0 with core_req_i=0, response ignored.
REQ-032 With PANDA_DATA_TIMEOUT_EN and TimeoutCycles=4, gnt never asserted -> DONE after 4 REQ cycles, core_err_o=1, core_rdata_o=0.
REQ-033 Spurious rvalid in IDLE with core_req_i=0 -> no state change, core_rdata_o unchanged.
